// File: rtl/mmio_control_registers.sv
// mmio_control_registers
// Word-addressed control/status register block behind a simple req/ack MMIO
// port. A three-state handshake FSM serves one access at a time. Writes take
// priority over reads. All register updates and read-data captures happen on
// the edge that leaves IDLE.

module mmio_control_registers #(
  parameter logic [31:0] ID_VALUE                = 32'h7141_0001,
  parameter logic [31:0] UNMAPPED_VALUE          = 32'hDEAD_BEEF,
  parameter int          AXI4_LITE_ADDRESS_WIDTH = 32
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  input  logic                               read_req,
  output logic                               read_ack,
  input  logic [AXI4_LITE_ADDRESS_WIDTH-1:0] read_address,
  output logic [31:0]                        read_data,
  input  logic                               write_req,
  output logic                               write_ack,
  input  logic [AXI4_LITE_ADDRESS_WIDTH-1:0] write_address,
  input  logic [31:0]                        write_data,
  output logic                               core_enable,
  output logic                               core_soft_reset,
  input  logic                               core_done,
  input  logic                               core_halted
);

  // Word offsets of the mapped registers (address bits [4:2])
  localparam logic [2:0] OFF_ID          = 3'd0;
  localparam logic [2:0] OFF_CONTROL     = 3'd1;
  localparam logic [2:0] OFF_STATUS      = 3'd2;
  localparam logic [2:0] OFF_SCRATCH     = 3'd3;
  localparam logic [2:0] OFF_CYCLE_COUNT = 3'd4;
  localparam logic [2:0] OFF_ERROR_ADDR  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE_ACK = 2'd1,
    ST_READ_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] read_data_q, read_data_d;
  logic        enable_q, enable_d;
  logic        soft_reset_q, soft_reset_d;
  logic        done_sticky_q, done_sticky_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] error_addr_q, error_addr_d;

  logic        write_commit;
  logic        read_capture;
  logic        write_mapped;
  logic        read_mapped;
  logic [2:0]  write_offset;
  logic [2:0]  read_offset;
  logic        done_clear;
  logic [31:0] read_value;

  // An address is mapped only when every bit above [4:2] is zero and the
  // word offset lands on one of the six implemented registers.
  function automatic logic addr_is_mapped(input logic [AXI4_LITE_ADDRESS_WIDTH-1:0] addr);
    return ((addr >> 5) == '0) && (addr[4:2] <= OFF_ERROR_ADDR);
  endfunction

  assign write_offset = write_address[4:2];
  assign read_offset  = read_address[4:2];
  assign write_mapped = addr_is_mapped(write_address);
  assign read_mapped  = addr_is_mapped(read_address);

  // Handshake FSM next state; the IDLE exit edge is where work is committed
  always_comb begin
    state_d      = state_q;
    write_commit = 1'b0;
    read_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (write_req) begin
          state_d      = ST_WRITE_ACK;
          write_commit = 1'b1;
        end else if (read_req) begin
          state_d      = ST_READ_ACK;
          read_capture = 1'b1;
        end
      end
      ST_WRITE_ACK: state_d = ST_IDLE;
      ST_READ_ACK:  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Read multiplexer over the current register contents
  always_comb begin
    read_value = UNMAPPED_VALUE;
    if (read_mapped) begin
      case (read_offset)
        OFF_ID:          read_value = ID_VALUE;
        OFF_CONTROL:     read_value = {30'b0, 1'b0, enable_q};
        OFF_STATUS:      read_value = {30'b0, core_halted, done_sticky_q};
        OFF_SCRATCH:     read_value = scratch_q;
        OFF_CYCLE_COUNT: read_value = cycle_count_q;
        OFF_ERROR_ADDR:  read_value = error_addr_q;
        default:         read_value = UNMAPPED_VALUE;
      endcase
    end
  end

  // Register file next-state: write decode, read capture, sticky and counter
  always_comb begin
    enable_d      = enable_q;
    soft_reset_d  = 1'b0;
    scratch_d     = scratch_q;
    error_addr_d  = error_addr_q;
    read_data_d   = read_data_q;
    done_clear    = 1'b0;

    if (write_commit) begin
      if (!write_mapped) begin
        error_addr_d = 32'(write_address);
      end else begin
        case (write_offset)
          OFF_CONTROL: begin
            enable_d     = write_data[0];
            soft_reset_d = write_data[1];
          end
          OFF_STATUS:  done_clear = write_data[0];
          OFF_SCRATCH: scratch_d  = write_data;
          default:     ;
        endcase
      end
    end

    if (read_capture) begin
      read_data_d = read_value;
      if (!read_mapped) begin
        error_addr_d = 32'(read_address);
      end
    end

    // A new completion pulse beats a simultaneous write-one-to-clear
    done_sticky_d = core_done | (done_sticky_q & ~done_clear);

    // The soft-reset pulse cycle clears the counter ahead of any increment
    if (soft_reset_q) begin
      cycle_count_d = 32'd0;
    end else if (enable_q && !done_sticky_q) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end else begin
      cycle_count_d = cycle_count_q;
    end
  end

  // State and register flops with asynchronous active-low reset
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= ST_IDLE;
      read_data_q   <= 32'd0;
      enable_q      <= 1'b0;
      soft_reset_q  <= 1'b0;
      done_sticky_q <= 1'b0;
      scratch_q     <= 32'd0;
      cycle_count_q <= 32'd0;
      error_addr_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      read_data_q   <= read_data_d;
      enable_q      <= enable_d;
      soft_reset_q  <= soft_reset_d;
      done_sticky_q <= done_sticky_d;
      scratch_q     <= scratch_d;
      cycle_count_q <= cycle_count_d;
      error_addr_q  <= error_addr_d;
    end
  end

  assign write_ack       = (state_q == ST_WRITE_ACK);
  assign read_ack        = (state_q == ST_READ_ACK);
  assign read_data       = read_data_q;
  assign core_enable     = enable_q;
  assign core_soft_reset = soft_reset_q;

endmodule
